// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage program counter and fetch/decode pipeline register.
// Applies redirect / bubble / stall requests with fixed priority, and keeps
// debug counters (bubbles, branch hazards) plus a sticky stall watchdog.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000,
  parameter int unsigned MAX_STALL = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        need_nop,
  input  logic        pc_stall,
  input  logic        branch_hazard,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_pc,
  input  logic [0:31] imem_instr,
  output logic [0:31] fetch_pc,
  output logic [0:31] fetch_pc_plus_4,
  output logic [0:31] decode_instr,
  output logic [0:31] decode_pc_plus_4,
  output logic        decode_valid,
  output logic [0:15] bubble_count,
  output logic [0:15] hazard_count,
  output logic        stall_timeout
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  stall_cnt;
  logic        hold;
  logic        hold_cycle;
  logic [4:0]  stall_cnt_inc;

  // A redirect overrides any stall request, so only hold without redirect
  // counts as a stall cycle.
  assign hold            = pc_stall | need_nop;
  assign hold_cycle      = hold & ~redirect_valid;
  assign fetch_pc_plus_4 = fetch_pc + 32'd4;
  assign stall_cnt_inc   = {1'b0, stall_cnt} + 5'd1;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: the state just mirrors this cycle's dominant request
  always_comb begin
    state_next = RUN;
    if (redirect_valid) begin
      state_next = FLUSH;
    end else if (hold) begin
      state_next = STALL;
    end
  end

  // PC and fetch/decode register, priority redirect > bubble > stall > advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc         <= RESET_PC;
      decode_instr     <= NOP_INSTR;
      decode_pc_plus_4 <= 32'd0;
      decode_valid     <= 1'b0;
    end else if (redirect_valid) begin
      // The instruction in fetch is on the wrong path: flush it.
      fetch_pc         <= redirect_pc;
      decode_instr     <= NOP_INSTR;
      decode_pc_plus_4 <= fetch_pc_plus_4;
      decode_valid     <= 1'b0;
    end else if (need_nop) begin
      // Bubble: decode_pc_plus_4 deliberately keeps its old value.
      decode_instr     <= NOP_INSTR;
      decode_valid     <= 1'b0;
    end else if (pc_stall) begin
      decode_instr     <= imem_instr;
      decode_pc_plus_4 <= fetch_pc_plus_4;
      decode_valid     <= 1'b1;
    end else begin
      fetch_pc         <= fetch_pc_plus_4;
      decode_instr     <= imem_instr;
      decode_pc_plus_4 <= fetch_pc_plus_4;
      decode_valid     <= 1'b1;
    end
  end

  // Stall watchdog: saturating run-length of hold cycles, sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt     <= 4'd0;
      stall_timeout <= 1'b0;
    end else if (hold_cycle) begin
      if (stall_cnt != 4'hF) begin
        stall_cnt <= stall_cnt + 4'd1;
      end
      if (32'(stall_cnt_inc) >= MAX_STALL) begin
        stall_timeout <= 1'b1;
      end
    end else begin
      stall_cnt <= 4'd0;
    end
  end

  // Debug event counters, both wrap naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= 16'd0;
      hazard_count <= 16'd0;
    end else begin
      if (redirect_valid | need_nop) begin
        bubble_count <= bubble_count + 16'd1;
      end
      if (branch_hazard) begin
        hazard_count <= hazard_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with a combinational imem model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        need_nop;
  logic        pc_stall;
  logic        branch_hazard;
  logic        redirect_valid;
  logic [0:31] redirect_pc;
  logic [0:31] imem_instr;
  logic [0:31] fetch_pc;
  logic [0:31] fetch_pc_plus_4;
  logic [0:31] decode_instr;
  logic [0:31] decode_pc_plus_4;
  logic        decode_valid;
  logic [0:15] bubble_count;
  logic [0:15] hazard_count;
  logic        stall_timeout;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(
    .RESET_PC (32'h00000100),
    .NOP_INSTR(32'h00000000),
    .MAX_STALL(15)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .need_nop        (need_nop),
    .pc_stall        (pc_stall),
    .branch_hazard   (branch_hazard),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_instr      (imem_instr),
    .fetch_pc        (fetch_pc),
    .fetch_pc_plus_4 (fetch_pc_plus_4),
    .decode_instr    (decode_instr),
    .decode_pc_plus_4(decode_pc_plus_4),
    .decode_valid    (decode_valid),
    .bubble_count    (bubble_count),
    .hazard_count    (hazard_count),
    .stall_timeout   (stall_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0000;
  endfunction

  assign imem_instr = instr_at(fetch_pc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, fetch_pc, 32'h100);
    check({tag, "_instr"}, decode_instr, 32'h0);
    check({tag, "_pc4"}, decode_pc_plus_4, 32'h0);
    check({tag, "_valid"}, 32'(decode_valid), 32'h0);
    check({tag, "_bub"}, 32'(bubble_count), 32'h0);
    check({tag, "_haz"}, 32'(hazard_count), 32'h0);
    check({tag, "_tmo"}, 32'(stall_timeout), 32'h0);
  endtask

  initial begin
    rst = 1'b1; need_nop = 0; pc_stall = 0; branch_hazard = 0;
    redirect_valid = 0; redirect_pc = '0;
    #2;
    check_reset("rst_async");
    step();
    check_reset("rst_held");
    rst = 1'b0;

    // Sequential fetch from RESET_PC
    step();
    $display("seq1 pc=%h dpc4=%h", fetch_pc, decode_pc_plus_4);
    check("seq1_pc", fetch_pc, 32'h104);
    check("seq1_pc4", decode_pc_plus_4, 32'h104);
    check("seq1_instr", decode_instr, instr_at(32'h100));
    check("seq1_valid", 32'(decode_valid), 32'h1);
    step();
    check("seq2_pc", fetch_pc, 32'h108);
    check("seq2_pc4", decode_pc_plus_4, 32'h108);

    // Load-use bubble at 108
    need_nop = 1; pc_stall = 1;
    step();
    $display("bubble pc=%h instr=%h valid=%0d", fetch_pc, decode_instr, decode_valid);
    check("lu_pc", fetch_pc, 32'h108);
    check("lu_instr", decode_instr, 32'h0);
    check("lu_valid", 32'(decode_valid), 32'h0);
    check("lu_pc4", decode_pc_plus_4, 32'h108);
    check("lu_bub", 32'(bubble_count), 32'h1);
    need_nop = 0; pc_stall = 0;
    step();
    check("lu2_instr", decode_instr, instr_at(32'h108));
    check("lu2_valid", 32'(decode_valid), 32'h1);
    check("lu2_pc", fetch_pc, 32'h10C);
    step();
    check("adv_pc", fetch_pc, 32'h110);

    // pc_stall alone at 110
    pc_stall = 1; branch_hazard = 1;
    step();
    $display("stall pc=%h instr=%h", fetch_pc, decode_instr);
    check("st_pc", fetch_pc, 32'h110);
    check("st_instr", decode_instr, instr_at(32'h110));
    check("st_valid", 32'(decode_valid), 32'h1);
    check("st_pc4", decode_pc_plus_4, 32'h114);
    check("st_bub", 32'(bubble_count), 32'h1);
    check("st_haz", 32'(hazard_count), 32'h1);
    pc_stall = 0; branch_hazard = 0;
    step();
    check("rel_pc", fetch_pc, 32'h114);

    // Redirect wins over need_nop
    redirect_valid = 1; redirect_pc = 32'h200; need_nop = 1; branch_hazard = 1;
    step();
    $display("redirect pc=%h instr=%h valid=%0d", fetch_pc, decode_instr, decode_valid);
    check("rd_pc", fetch_pc, 32'h200);
    check("rd_instr", decode_instr, 32'h0);
    check("rd_valid", 32'(decode_valid), 32'h0);
    check("rd_pc4", decode_pc_plus_4, 32'h118);
    check("rd_bub", 32'(bubble_count), 32'h2);
    check("rd_haz", 32'(hazard_count), 32'h2);
    check("rd_state", 32'(dut.state), 32'(2));
    redirect_valid = 0; need_nop = 0; branch_hazard = 0;
    step();
    check("rd2_instr", decode_instr, instr_at(32'h200));
    check("rd2_pc4", decode_pc_plus_4, 32'h204);
    check("rd2_valid", 32'(decode_valid), 32'h1);
    check("rd2_pc", fetch_pc, 32'h204);

    // Watchdog: 15 consecutive hold cycles
    pc_stall = 1;
    for (int i = 1; i <= 14; i++) begin
      step();
      check("wd_pre", 32'(stall_timeout), 32'h0);
    end
    step();
    $display("watchdog timeout=%0d", stall_timeout);
    check("wd_set", 32'(stall_timeout), 32'h1);
    check("wd_pc", fetch_pc, 32'h204);
    pc_stall = 0;
    step();
    check("wd_sticky", 32'(stall_timeout), 32'h1);
    check("wd_relpc", fetch_pc, 32'h208);

    // PC wrap
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0;
    check("wr_pc", fetch_pc, 32'hFFFF_FFFC);
    check("wr_pc4c", fetch_pc_plus_4, 32'h0);
    check("wr_bub", 32'(bubble_count), 32'h3);
    step();
    $display("wrap pc=%h dpc4=%h", fetch_pc, decode_pc_plus_4);
    check("wr2_pc", fetch_pc, 32'h0);
    check("wr2_pc4", decode_pc_plus_4, 32'h0);
    check("wr2_instr", decode_instr, instr_at(32'hFFFF_FFFC));

    // Async reset in the middle of a stall
    pc_stall = 1;
    step();
    #2;
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    $display("mid-stall reset pc=%h", fetch_pc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage PC and fetch/decode pipeline-register controller; acts on the stall/bubble requests raised by the fetch-stage hazard unit. Owns the program counter, drives the instruction-memory address, and loads the fetch/decode register with the fetched instruction, a NOP bubble, or a flush. Tracks stall/flush state in a small FSM and keeps a bubble counter and a stall watchdog for debug.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset
- NOP_INSTR, 32'h00000000, encoding inserted as a bubble/flush
- MAX_STALL, 15, consecutive-hold cycles at which stall_timeout asserts (1..15)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- need_nop  input  1  insert bubble into decode this cycle; PC holds
- pc_stall  input  1  hold PC this cycle
- branch_hazard  input  1  branch operand hazard (subset of need_nop); counted only
- redirect_valid  input  1  taken branch/jump resolved in decode
- redirect_pc  input  [0:31]  redirect target
- imem_instr  input  [0:31]  instruction at fetch_pc (combinational imem)
- fetch_pc  output  [0:31]  current PC / imem address
- fetch_pc_plus_4  output  [0:31]  fetch_pc + 4, combinational
- decode_instr  output  [0:31]  fetch/decode register instruction
- decode_pc_plus_4  output  [0:31]  fetch/decode register PC+4
- decode_valid  output  1  decode_instr is a real instruction (0 for bubble/flush)
- bubble_count  output  [0:15]  bubbles + flushes inserted, wraps
- hazard_count  output  [0:15]  cycles with branch_hazard=1, wraps
- stall_timeout  output  1  sticky until reset; consecutive hold reached MAX_STALL

## Operation
- Bit 0 is MSB on all buses; PC arithmetic modulo 2^32 (32'hFFFFFFFC + 4 = 0).
- hold = pc_stall | need_nop. Per-cycle priority, highest first:
  - redirect_valid: fetch_pc <= redirect_pc; decode <= {NOP_INSTR, redirect_pc+4 not used: decode_pc_plus_4 <= fetch_pc_plus_4}, decode_valid <= 0; stall inputs ignored.
  - need_nop: fetch_pc holds; decode_instr <= NOP_INSTR, decode_pc_plus_4 holds, decode_valid <= 0.
  - pc_stall only: fetch_pc holds; decode <= {imem_instr, fetch_pc_plus_4}, decode_valid <= 1.
  - else: fetch_pc <= fetch_pc+4; decode <= {imem_instr, fetch_pc_plus_4}, decode_valid <= 1.
- FSM states RUN, STALL, FLUSH (state encoding internal):
  - any state -> FLUSH on redirect_valid.
  - any state -> STALL on hold without redirect.
  - any state -> RUN otherwise.
- Stall counter: 4-bit, increments (saturating at 15) each cycle in which hold=1 and redirect_valid=0; clears on any other cycle. stall_timeout sets when counter+1 reaches MAX_STALL in a hold cycle.
- bubble_count increments on each cycle with redirect_valid | need_nop; hazard_count on each cycle with branch_hazard=1; both wrap 16'hFFFF -> 0.

## Timing
- All registered outputs update on the rising edge after inputs are sampled; fetch_pc_plus_4 is combinational from fetch_pc.
- Reset (async, immediate): fetch_pc=RESET_PC, decode_instr=NOP_INSTR, decode_pc_plus_4=0, decode_valid=0, counters=0, stall_timeout=0, FSM=RUN. Reset mid-stall or mid-flush discards all state.
- First real instruction reaches decode one edge after rst deasserts.
- Redirect: new PC appears at fetch_pc one edge later; target instruction reaches decode two edges after redirect_valid; exactly one flush bubble.
- Load-use: need_nop and pc_stall high one cycle -> one bubble, instruction stays in fetch and enters decode the following edge.

## Test plan
- Reset with RESET_PC=32'h100, no hazards, 3 edges -> fetch_pc 104,108,10C; decode_pc_plus_4 104,108; decode_valid 1 from first edge.
- need_nop=pc_stall=1 for one cycle at fetch_pc=32'h108 -> fetch_pc stays 108, decode_instr=NOP, decode_valid=0, bubble_count=1; next edge decode gets instr@108.
- pc_stall alone at 32'h110 -> decode gets instr@110 valid, fetch_pc held 110; release -> fetch_pc=114.
- redirect_valid with redirect_pc=32'h200 while need_nop=1 -> fetch_pc=200, decode NOP invalid, FSM FLUSH; next edge decode holds instr@200, pc_plus_4=204.
- hold for 15 consecutive cycles (MAX_STALL=15) -> stall_timeout=1 after 15th edge, stays 1 after hold drops until rst.
- fetch_pc=32'hFFFFFFFC, no hazards -> fetch_pc wraps to 0; assert rst during stall -> all outputs at reset values immediately, without a clock edge.
